// File: rtl/decoder_pkg.sv
// Shared types and constants for the x86-64 length/field decoder.
// Combinational only; no latency.
// No flow control; types only.
package decoder_pkg;

    localparam int WINDOW_BYTES = 15;
    localparam int MAX_PREFIX   = 4;

    localparam logic [7:0] PFX_OPSZ  = 8'h66;
    localparam logic [7:0] PFX_REPNE = 8'hF2;
    localparam logic [7:0] PFX_REP   = 8'hF3;
    localparam logic [7:0] PFX_LOCK  = 8'hF0;
    localparam logic [7:0] PFX_CS    = 8'h2E;
    localparam logic [7:0] PFX_SS    = 8'h36;
    localparam logic [7:0] PFX_DS    = 8'h3E;
    localparam logic [7:0] PFX_ES    = 8'h26;
    localparam logic [7:0] PFX_FS    = 8'h64;
    localparam logic [7:0] PFX_GS    = 8'h65;

    // Segment override code carried in decoded_insn_t.seg
    localparam logic [2:0] SEG_NONE = 3'd0;
    localparam logic [2:0] SEG_ES   = 3'd1;
    localparam logic [2:0] SEG_CS   = 3'd2;
    localparam logic [2:0] SEG_SS   = 3'd3;
    localparam logic [2:0] SEG_DS   = 3'd4;
    localparam logic [2:0] SEG_FS   = 3'd5;
    localparam logic [2:0] SEG_GS   = 3'd6;

    typedef enum logic [2:0] {
        IMM_NONE, IMM8, IMM16_32, IMM64, REL8, REL32
    } imm_kind_e;

    typedef struct packed {
        logic [3:0] def;
        logic       w;
        logic       r;
        logic       x;
        logic       b;
    } rex_t;

    typedef struct packed {
        logic [1:0] mod;
        logic [2:0] regop;
        logic [2:0] rm;
    } modrm_t;

    typedef struct packed {
        logic [1:0] scale;
        logic [2:0] index;
        logic [2:0] base;
    } sib_t;

    typedef struct packed {
        logic [3:0]  len;
        logic        opsz66;
        logic        rep;
        logic        repne;
        logic        lock;
        logic [2:0]  seg;
        rex_t        rex;
        logic        two_byte;
        logic [7:0]  opcode;
        logic        has_modrm;
        modrm_t      modrm;
        logic        has_sib;
        sib_t        sib;
        logic [63:0] disp;
        logic [63:0] imm;
        logic        illegal;
    } decoded_insn_t;

    function automatic logic is_legacy_prefix(input logic [7:0] b);
        return b inside {PFX_OPSZ, PFX_REPNE, PFX_REP, PFX_LOCK, PFX_CS,
                         PFX_SS, PFX_DS, PFX_ES, PFX_FS, PFX_GS};
    endfunction

endpackage

// File: rtl/x86_opcode_table.sv
// Opcode classifier: operand shape (modrm, immediate kind/size) and legality.
// Purely combinational, zero latency.
// No flow control; evaluated every cycle.
module x86_opcode_table
    import decoder_pkg::*;
(
    input  logic       two_byte,
    input  logic [7:0] opcode,
    input  logic       opsz66,
    input  logic       rex_w,
    output logic       has_modrm,
    output imm_kind_e  imm_kind,
    output logic [3:0] imm_sz,
    output logic       legal
);

    // Classify the opcode, then size its immediate from 66/REX.W
    always_comb begin
        has_modrm = 1'b0;
        imm_kind  = IMM_NONE;
        legal     = 1'b1;
        if (two_byte) begin
            if (opcode == 8'h05) begin
                imm_kind = IMM_NONE;
            end else if (opcode[7:4] == 4'h8) begin
                imm_kind = REL32;
            end else if (opcode inside {8'hAF, 8'hB6, 8'hB7}) begin
                has_modrm = 1'b1;
            end else begin
                legal = 1'b0;
            end
        end else if (opcode[7:6] == 2'b00) begin
            // ALU block: low 3 bits 0-3 modrm forms, 4 imm8, 5 imm16/32
            if (!opcode[2])                 has_modrm = 1'b1;
            else if (opcode[1:0] == 2'b00)  imm_kind  = IMM8;
            else if (opcode[1:0] == 2'b01)  imm_kind  = IMM16_32;
            else                            legal     = 1'b0;
        end else if (opcode[7:4] == 4'h5 || opcode == 8'h90 || opcode == 8'hC3) begin
            imm_kind = IMM_NONE;
        end else if (opcode[7:4] == 4'h7 || opcode == 8'hEB) begin
            imm_kind = REL8;
        end else if (opcode == 8'hE8 || opcode == 8'hE9) begin
            imm_kind = REL32;
        end else if (opcode == 8'h80 || opcode == 8'h83) begin
            has_modrm = 1'b1;
            imm_kind  = IMM8;
        end else if (opcode == 8'h81 || opcode == 8'hC7) begin
            has_modrm = 1'b1;
            imm_kind  = IMM16_32;
        end else if ((opcode >= 8'h84 && opcode <= 8'h8B) || opcode == 8'h8D) begin
            has_modrm = 1'b1;
        end else if (opcode[7:3] == 5'b10111) begin
            imm_kind = rex_w ? IMM64 : IMM16_32;
        end else begin
            legal = 1'b0;
        end

        case (imm_kind)
            IMM8, REL8: imm_sz = 4'd1;
            IMM16_32:   imm_sz = opsz66 ? 4'd2 : 4'd4;
            REL32:      imm_sz = 4'd4;
            IMM64:      imm_sz = 4'd8;
            default:    imm_sz = 4'd0;
        endcase
    end

endmodule

// File: rtl/x86_insn_decoder.sv
// x86-64 length/field decoder; optional counters under DECODER_STATS_EN.
// in_taken combinational same cycle; decoded fields registered, 1-cycle latency.
// Accepts only when the slot is empty or draining; flush drops the slot and takes nothing.
module x86_insn_decoder
    import decoder_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [WINDOW_BYTES*8-1:0] in_bytes,
    output logic [3:0]                in_taken,
    output logic                      out_valid,
    input  logic                      out_ready,
    output decoded_insn_t             out_insn
`ifdef DECODER_STATS_EN
    ,
    output logic [31:0]               stat_insns,
    output logic [31:0]               stat_illegal
`endif
);

    localparam logic [4:0] MAX_PFX_CNT = 5'(MAX_PREFIX);

    logic [319:0]  win_pad;
    logic [4:0]    pfx_len, n_legacy;
    logic          scanning, rex_last, pf_opsz66, pf_rep, pf_repne, pf_lock;
    logic [7:0]    rex_byte, cur, first_b;
    logic [2:0]    pf_seg;
    logic          two_byte, tbl_modrm, tbl_legal, has_sib, accept;
    logic [7:0]    opcode, modrm_b, sib_b;
    imm_kind_e     tbl_kind;
    logic [3:0]    imm_sz;
    logic [5:0]    pos_modrm, pos_disp, pos_imm, total, disp_sz;
    logic [63:0]   disp_raw, imm_raw, disp_val, imm_val;
    decoded_insn_t dec;
    logic          out_valid_d, out_valid_q;
    decoded_insn_t out_insn_d, out_insn_q;

    // Zero padding lets field reads run past the window without range checks;
    // any such instruction is over-length and flagged illegal anyway.
    assign win_pad  = {200'd0, in_bytes};
    assign first_b  = win_pad[{1'b0, pfx_len, 3'b000} +: 8];
    assign two_byte = (first_b == 8'h0F);
    assign opcode   = two_byte ? win_pad[{1'b0, pfx_len + 5'd1, 3'b000} +: 8] : first_b;

    // Walk the run of legacy/REX prefixes; later prefixes in a group override earlier ones
    always_comb begin
        pfx_len   = '0;
        n_legacy  = '0;
        scanning  = 1'b1;
        rex_last  = 1'b0;
        rex_byte  = '0;
        cur       = '0;
        pf_opsz66 = 1'b0;
        pf_rep    = 1'b0;
        pf_repne  = 1'b0;
        pf_lock   = 1'b0;
        pf_seg    = SEG_NONE;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            cur = in_bytes[i*8 +: 8];
            if (scanning) begin
                if (is_legacy_prefix(cur)) begin
                    pfx_len  = pfx_len + 5'd1;
                    n_legacy = n_legacy + 5'd1;
                    rex_last = 1'b0;  // a REX not adjacent to the opcode is dead
                    case (cur)
                        PFX_OPSZ:  pf_opsz66 = 1'b1;
                        PFX_REPNE: begin pf_repne = 1'b1; pf_rep = 1'b0; end
                        PFX_REP:   begin pf_rep = 1'b1; pf_repne = 1'b0; end
                        PFX_LOCK:  pf_lock = 1'b1;
                        PFX_ES:    pf_seg = SEG_ES;
                        PFX_CS:    pf_seg = SEG_CS;
                        PFX_SS:    pf_seg = SEG_SS;
                        PFX_DS:    pf_seg = SEG_DS;
                        PFX_FS:    pf_seg = SEG_FS;
                        PFX_GS:    pf_seg = SEG_GS;
                        default:   pf_seg = pf_seg;
                    endcase
                end else if (cur[7:4] == 4'h4) begin
                    pfx_len  = pfx_len + 5'd1;
                    rex_last = 1'b1;
                    rex_byte = cur;
                end else begin
                    scanning = 1'b0;
                end
            end
        end
    end

    x86_opcode_table u_opcode_table (
        .two_byte  (two_byte),
        .opcode    (opcode),
        .opsz66    (pf_opsz66),
        .rex_w     (rex_last & rex_byte[3]),
        .has_modrm (tbl_modrm),
        .imm_kind  (tbl_kind),
        .imm_sz    (imm_sz),
        .legal     (tbl_legal)
    );

    // Locate modrm/sib/disp/imm, extract them and assemble the decoded record
    always_comb begin
        pos_modrm = {1'b0, pfx_len} + (two_byte ? 6'd2 : 6'd1);
        modrm_b   = win_pad[{1'b0, pos_modrm[4:0], 3'b000} +: 8];
        sib_b     = win_pad[{1'b0, pos_modrm[4:0] + 5'd1, 3'b000} +: 8];
        has_sib   = tbl_modrm && (modrm_b[7:6] != 2'b11) && (modrm_b[2:0] == 3'd4);
        disp_sz   = 6'd0;
        if (tbl_modrm) begin
            case (modrm_b[7:6])
                2'b00:   if (modrm_b[2:0] == 3'd5 || (has_sib && sib_b[2:0] == 3'd5)) disp_sz = 6'd4;
                2'b01:   disp_sz = 6'd1;
                2'b10:   disp_sz = 6'd4;
                default: disp_sz = 6'd0;
            endcase
        end
        pos_disp = pos_modrm + {5'd0, tbl_modrm} + {5'd0, has_sib};
        pos_imm  = pos_disp + disp_sz;
        total    = pos_imm + {2'b00, imm_sz};
        disp_raw = win_pad[{1'b0, pos_disp[4:0], 3'b000} +: 64];
        imm_raw  = win_pad[{1'b0, pos_imm[4:0], 3'b000} +: 64];

        case (disp_sz)
            6'd1:    disp_val = {{56{disp_raw[7]}}, disp_raw[7:0]};
            6'd4:    disp_val = {{32{disp_raw[31]}}, disp_raw[31:0]};
            default: disp_val = '0;
        endcase
        case (tbl_kind)
            IMM8, REL8: imm_val = {{56{imm_raw[7]}}, imm_raw[7:0]};
            IMM16_32:   imm_val = pf_opsz66 ? {{48{imm_raw[15]}}, imm_raw[15:0]}
                                            : {{32{imm_raw[31]}}, imm_raw[31:0]};
            REL32:      imm_val = {{32{imm_raw[31]}}, imm_raw[31:0]};
            IMM64:      imm_val = imm_raw;
            default:    imm_val = '0;
        endcase

        dec = '0;
        if (!tbl_legal || (n_legacy > MAX_PFX_CNT) || (total > 6'd15)) begin
            dec.len     = 4'd1;
            dec.illegal = 1'b1;
        end else begin
            dec.len       = total[3:0];
            dec.opsz66    = pf_opsz66;
            dec.rep       = pf_rep;
            dec.repne     = pf_repne;
            dec.lock      = pf_lock;
            dec.seg       = pf_seg;
            dec.rex       = rex_last ? rex_t'(rex_byte) : '0;
            dec.two_byte  = two_byte;
            dec.opcode    = opcode;
            dec.has_modrm = tbl_modrm;
            dec.modrm     = tbl_modrm ? modrm_t'(modrm_b) : '0;
            dec.has_sib   = has_sib;
            dec.sib       = has_sib ? sib_t'(sib_b) : '0;
            dec.disp      = disp_val;
            dec.imm       = imm_val;
        end
    end

    assign accept   = in_valid && !flush && !reset && (!out_valid_q || out_ready);
    assign in_taken = accept ? dec.len : 4'd0;

    // Output slot: flush beats accept, accept beats drain
    always_comb begin
        out_valid_d = out_valid_q;
        out_insn_d  = out_insn_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_insn_d  = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output slot registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_insn_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_insn_q  <= out_insn_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_insn  = out_insn_q;

`ifdef DECODER_STATS_EN
    logic [31:0] stat_insns_d, stat_insns_q, stat_illegal_d, stat_illegal_q;

    // Free-running wrap-around counters; flush leaves them alone
    always_comb begin
        stat_insns_d   = stat_insns_q + {31'd0, accept};
        stat_illegal_d = stat_illegal_q + {31'd0, accept & dec.illegal};
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_insns_q   <= '0;
            stat_illegal_q <= '0;
        end else begin
            stat_insns_q   <= stat_insns_d;
            stat_illegal_q <= stat_illegal_d;
        end
    end

    assign stat_insns   = stat_insns_q;
    assign stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_x86_insn_decoder.sv
// Self-checking bench for x86_insn_decoder: directed cases, backpressure/flush, random windows.
// Expected values come from a byte-walking reference decoder inside the bench.
// Stats checks compile in when DECODER_STATS_EN is defined.
module tb_x86_insn_decoder;
    import decoder_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [119:0]  in_bytes = '0;
    logic [3:0]    in_taken;
    logic          out_valid;
    logic          out_ready = 1'b1;
    decoded_insn_t out_insn;
`ifdef DECODER_STATS_EN
    logic [31:0]   stat_insns, stat_illegal;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    x86_insn_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_bytes  (in_bytes),
        .in_taken  (in_taken),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_insn  (out_insn)
`ifdef DECODER_STATS_EN
        ,
        .stat_insns   (stat_insns),
        .stat_illegal (stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_insn(input string tag, input decoded_insn_t exp);
        n_tests++;
        assert (out_insn === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, out_insn, exp);
        end
    endtask

    // Reference decoder: walk the bytes in order, summing field sizes.
    function automatic decoded_insn_t ref_decode(input logic [119:0] win);
        decoded_insn_t d;
        logic [7:0]  b [48];
        logic [7:0]  rexb, opc, m, s;
        logic [63:0] v;
        logic        rex_ok, rw, legal, mrm;
        int          p, nleg, n, dsz, isz, md, rm;
        for (int i = 0; i < 48; i++) begin
            if (i < 15) b[i] = win[i*8 +: 8];
            else        b[i] = 8'h00;
        end
        d = '0; p = 0; nleg = 0; rex_ok = 1'b0; rexb = '0; s = '0;
        while (p < 15 && (b[p] inside {8'h66, 8'hF2, 8'hF3, 8'hF0, 8'h2E, 8'h36,
                                       8'h3E, 8'h26, 8'h64, 8'h65} || b[p][7:4] == 4'h4)) begin
            if (b[p][7:4] == 4'h4) begin
                rex_ok = 1'b1;
                rexb   = b[p];
            end else begin
                rex_ok = 1'b0;
                nleg++;
                case (b[p])
                    8'h66: d.opsz66 = 1'b1;
                    8'hF3: begin d.rep = 1'b1; d.repne = 1'b0; end
                    8'hF2: begin d.repne = 1'b1; d.rep = 1'b0; end
                    8'hF0: d.lock = 1'b1;
                    8'h26: d.seg = SEG_ES;
                    8'h2E: d.seg = SEG_CS;
                    8'h36: d.seg = SEG_SS;
                    8'h3E: d.seg = SEG_DS;
                    8'h64: d.seg = SEG_FS;
                    default: d.seg = SEG_GS;
                endcase
            end
            p++;
        end
        if (b[p] == 8'h0F) begin d.two_byte = 1'b1; opc = b[p+1]; n = p + 2; end
        else begin opc = b[p]; n = p + 1; end
        d.opcode = opc;
        rw = rex_ok && rexb[3];
        legal = 1'b1; mrm = 1'b0; isz = 0;
        if (d.two_byte) begin
            if (opc == 8'h05) isz = 0;
            else if (opc >= 8'h80 && opc <= 8'h8F) isz = 4;
            else if (opc inside {8'hAF, 8'hB6, 8'hB7}) mrm = 1'b1;
            else legal = 1'b0;
        end else if (opc < 8'h40) begin
            case (opc % 8)
                0, 1, 2, 3: mrm = 1'b1;
                4:          isz = 1;
                5:          isz = d.opsz66 ? 2 : 4;
                default:    legal = 1'b0;
            endcase
        end else if ((opc >= 8'h50 && opc <= 8'h5F) || opc == 8'h90 || opc == 8'hC3) isz = 0;
        else if ((opc >= 8'h70 && opc <= 8'h7F) || opc == 8'hEB) isz = 1;
        else if (opc == 8'hE8 || opc == 8'hE9) isz = 4;
        else if (opc == 8'h80 || opc == 8'h83) begin mrm = 1'b1; isz = 1; end
        else if (opc == 8'h81 || opc == 8'hC7) begin mrm = 1'b1; isz = d.opsz66 ? 2 : 4; end
        else if ((opc >= 8'h84 && opc <= 8'h8B) || opc == 8'h8D) mrm = 1'b1;
        else if (opc >= 8'hB8 && opc <= 8'hBF) isz = rw ? 8 : (d.opsz66 ? 2 : 4);
        else legal = 1'b0;

        dsz = 0;
        if (mrm) begin
            m = b[n]; n++;
            d.has_modrm = 1'b1;
            d.modrm = modrm_t'(m);
            md = int'(m) / 64;
            rm = int'(m) % 8;
            if (md != 3 && rm == 4) begin
                s = b[n]; n++;
                d.has_sib = 1'b1;
                d.sib = sib_t'(s);
            end
            if (md == 1) dsz = 1;
            else if (md == 2) dsz = 4;
            else if (md == 0 && (rm == 5 || (d.has_sib && int'(s) % 8 == 5))) dsz = 4;
        end
        v = '0;
        for (int k = 0; k < dsz; k++) v = v | (64'(b[n+k]) << (8*k));
        if (dsz > 0 && v[8*dsz-1]) v = v | (~64'd0 << (8*dsz));
        d.disp = v; n += dsz;
        v = '0;
        for (int k = 0; k < isz; k++) v = v | (64'(b[n+k]) << (8*k));
        if (isz > 0 && isz < 8 && v[8*isz-1]) v = v | (~64'd0 << (8*isz));
        d.imm = v; n += isz;

        if (!legal || nleg > MAX_PREFIX || n > 15) begin
            d = '0;
            d.len = 4'd1;
            d.illegal = 1'b1;
        end else begin
            d.len = 4'(n);
            d.rex = rex_ok ? rex_t'(rexb) : '0;
        end
        return d;
    endfunction

    // Build a window from bytes written in reading order; tail filled with CC.
    function automatic logic [119:0] mk(input logic [127:0] seq, input int n);
        logic [119:0] w;
        w = {15{8'hCC}};
        for (int i = 0; i < n; i++) w[i*8 +: 8] = seq[(n-1-i)*8 +: 8];
        return w;
    endfunction

    function automatic logic [119:0] rand_win();
        logic [119:0] w;
        logic [7:0]   pf [11];
        logic [7:0]   misc [6];
        int           n, k;
        pf   = '{8'h66, 8'hF2, 8'hF3, 8'hF0, 8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65, 8'h48};
        misc = '{8'hC3, 8'hC7, 8'hE8, 8'hE9, 8'hEB, 8'h90};
        for (int i = 0; i < 15; i++) w[i*8 +: 8] = 8'($urandom);
        n = 0;
        k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 6)) : int'($urandom_range(0, 3));
        repeat (k) begin
            w[n*8 +: 8] = pf[$urandom_range(0, 10)];
            n++;
        end
        if ($urandom_range(0, 2) == 0) begin
            w[n*8 +: 8] = 8'h40 | 8'($urandom_range(0, 15));
            n++;
        end
        case ($urandom_range(0, 7))
            0: k = 0;
            1: begin
                w[n*8 +: 8] = 8'h0F;
                n++;
                case ($urandom_range(0, 4))
                    0: w[n*8 +: 8] = 8'h05;
                    1: w[n*8 +: 8] = 8'h80 | 8'($urandom_range(0, 15));
                    2: w[n*8 +: 8] = 8'hAF;
                    3: w[n*8 +: 8] = 8'hB6 | 8'($urandom_range(0, 1));
                    default: k = 0;
                endcase
            end
            2: w[n*8 +: 8] = 8'hB8 | 8'($urandom_range(0, 7));
            3: w[n*8 +: 8] = 8'h80 + 8'($urandom_range(0, 13));
            4: w[n*8 +: 8] = misc[$urandom_range(0, 5)];
            5: w[n*8 +: 8] = 8'h70 | 8'($urandom_range(0, 15));
            6: w[n*8 +: 8] = 8'($urandom_range(0, 63));
            default: w[n*8 +: 8] = 8'h50 | 8'($urandom_range(0, 15));
        endcase
        return w;
    endfunction

    // Present one window with the slot free; check in_taken now and the slot next edge.
    task automatic send(input logic [119:0] win);
        decoded_insn_t e;
        e = ref_decode(win);
        in_bytes  = win;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;
        @(negedge clk);
        chk("in_taken", 64'(in_taken), 64'(e.len));
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'd1);
        chk_insn("out_insn", e);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_bytes  = mk(128'h4831C0, 3);
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_taken", 64'(in_taken), 64'd0);
        chk_insn("rst_out_insn", '0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        do_reset();

        // Directed cases
        send(mk(128'h4831C0, 3));
        chk("rex_w", 64'(out_insn.rex.w), 64'd1);
        chk("opc31", 64'(out_insn.opcode), 64'h31);
        chk("modrmC0", 64'(out_insn.modrm), 64'hC0);
        chk("nosib", 64'(out_insn.has_sib), 64'd0);

        send(mk(128'h48B8EFCDAB8967452301, 10));
        chk("len10", 64'(out_insn.len), 64'd10);
        chk("imm64", out_insn.imm, 64'h0123456789ABCDEF);

        send(mk(128'h8B442408, 4));
        chk("sib_len", 64'(out_insn.len), 64'd4);
        chk("has_sib", 64'(out_insn.has_sib), 64'd1);
        chk("sib24", 64'(out_insn.sib), 64'h24);
        chk("disp8", out_insn.disp, 64'h8);

        send(mk(128'h8B45F8, 3));
        chk("disp_neg", out_insn.disp, 64'hFFFFFFFFFFFFFFF8);

        send(mk(128'h6681C33412, 5));
        chk("len5", 64'(out_insn.len), 64'd5);
        chk("opsz66", 64'(out_insn.opsz66), 64'd1);
        chk("imm16", out_insn.imm, 64'h1234);

        send(mk(128'h666666666690, 6));
        chk("pfx_ill", 64'(out_insn.illegal), 64'd1);
        chk("pfx_len1", 64'(out_insn.len), 64'd1);

        send(mk(128'hD6, 1));
        chk("d6_ill", 64'(out_insn.illegal), 64'd1);
        chk("d6_len", 64'(out_insn.len), 64'd1);
        @(posedge clk);
        #1;
        chk("drain", 64'(out_valid), 64'd0);

        // Backpressure: slot full and consumer stalled
        send(mk(128'h4831C0, 3));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bytes  = mk(128'h8B45F8, 3);
        repeat (5) begin
            @(negedge clk);
            chk("bp_taken", 64'(in_taken), 64'd0);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_hold", 64'(out_insn.opcode), 64'h31);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 64'(in_taken), 64'd3);
        @(posedge clk);
        #1;
        chk("bp_next", out_insn.disp, 64'hFFFFFFFFFFFFFFF8);

        // Flush beats accept and ready
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("flush_taken", 64'(in_taken), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        flush    = 1'b0;
        in_valid = 1'b0;

        // Random windows against the reference decoder
        for (int t = 0; t < 400; t++) send(rand_win());

`ifdef DECODER_STATS_EN
        do_reset();
        chk("stat_i_rst", 64'(stat_insns), 64'd0);
        chk("stat_x_rst", 64'(stat_illegal), 64'd0);
        send(mk(128'h4831C0, 3));
        send(mk(128'hD6, 1));
        chk("stat_insns", 64'(stat_insns), 64'd2);
        chk("stat_illegal", 64'(stat_illegal), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("stat_flush", 64'(stat_insns), 64'd2);
        send(mk(128'h90, 1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_insns", 64'(stat_insns), 64'd0);
        chk("midrst_ill", 64'(stat_illegal), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/x86_insn_decoder.md
Name: x86_insn_decoder

Overview:
- Length-and-field decoder directly downstream of the fetch/decode byte buffer in the core.
- Each cycle it consumes one x86-64 instruction from a 15-byte window that starts at the current decode offset.
- It reports how many bytes were consumed so the buffer can advance its offset.
- It presents the decoded fields in a registered valid/ready output slot to the next stage.

Parameters:
WINDOW_BYTES, 15, bytes presented per cycle; also the maximum legal instruction length.
MAX_PREFIX, 4, maximum legacy prefixes accepted before the instruction is flagged illegal.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
flush  input  1  drop output slot contents (redirect); no bytes are taken that cycle
in_valid  input  1  window holds at least 15 valid bytes
in_bytes  input  120  window; byte i = in_bytes[i*8 +: 8], byte 0 is first
in_taken  output  4  bytes consumed this cycle; 0 when not accepting
out_valid  output  1  output slot full
out_ready  input  1  consumer accepts slot this cycle
out_insn  output  decoded_insn_t  fields: len[3:0], prefix flags (opsz66, rep, repne, lock, seg[2:0]), rex, two_byte, opcode[7:0], has_modrm, modrm, has_sib, sib, disp[63:0] sign-extended, imm[63:0], illegal

Behaviour:
- Reset: out_valid=0, out_insn=0, in_taken=0, stats counters=0.
- Accept condition: accept = in_valid & !flush & (!out_valid | out_ready).
- On accept: combinational decode; in_taken = len the same cycle; out_insn/out_valid=1 registered at the next edge (1-cycle latency).
- Not accepting: in_taken=0.
- Slot drain: out_ready & out_valid without a new accept → out_valid=0 next cycle.
- flush: out_valid=0 next cycle; wins over accept and over out_ready.
- Prefixes: 66, F2, F3, F0, 2E, 36, 3E, 26, 64, 65, in any order.
  - More than MAX_PREFIX prefixes → illegal.
  - Repeated prefix: last occurrence wins.
- REX (40-4F) counts only when it is the byte immediately before the opcode; a REX followed by a legacy prefix is ignored but still counted in len.
- Opcode map, one-byte:
  - 00-3F with low nibble 0-3 or 8-B: modrm.
  - Low nibble 4/C: imm8. Low nibble 5/D: imm32 (imm16 if 66).
  - 50-5F, 90, C3: no operands.
  - 70-7F, EB: rel8. E8, E9: rel32.
  - 84-8B, 8D: modrm.
  - 80, 83: modrm+imm8. 81, C7: modrm+imm32 (imm16 if 66).
  - B8-BF: imm32, or imm64 if REX.W.
- Opcode map, 0F escape (two_byte=1): 05 none; 80-8F rel32; AF, B6, B7 modrm.
- Any other opcode → illegal.
- ModRM:
  - mod!=3 & rm==4 → SIB present.
  - mod==0 & rm==5 → disp32 (RIP-relative).
  - mod==0 & SIB.base==5 → disp32.
  - mod==1 → disp8; mod==2 → disp32.
- Imm/disp: little-endian, sign-extended to 64 bits; imm64 is taken verbatim.
- Illegal (bad opcode, too many prefixes, or computed length >15): len=1, illegal=1, other fields 0. The bench must never see in_taken=0 while accepting.
- len = prefixes + rex + opcode bytes + modrm + sib + disp + imm; always 1..15.

Optional Feature:
- Macro: DECODER_STATS_EN.
- When defined:
  - Extra output ports stat_insns[31:0] and stat_illegal[31:0].
  - stat_insns increments on every accept; stat_illegal increments on accepts that are illegal.
  - Both wrap at 2^32, clear on reset, and are not cleared by flush.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package decoder_pkg holds:
  - rex_t (def[3:0], W, R, X, B) and modrm_t (mod, reg, rm).
  - sib_t (scale, index, base) and decoded_insn_t.
  - Prefix byte constants and the immediate-size enum (NONE, IMM8, IMM16_32, IMM64, REL8, REL32).
- One sub-module, x86_opcode_table: purely combinational; maps {two_byte, opcode, opsz66, rex.W} to {has_modrm, imm_kind, legal}.
- The top block holds prefix scan, length arithmetic, field extraction, the output register and the stats counters.

Test Plan:
- Bytes 48 31 C0 → in_taken=3; rex.W=1, opcode=31, modrm=C0, has_sib=0, next cycle out_valid=1.
- Bytes 48 B8 EF CD AB 89 67 45 23 01 → len=10, imm=0x0123456789ABCDEF.
- Bytes 8B 44 24 08 → len=4, has_sib=1, sib=24, disp=0x8. Bytes 8B 45 F8 → len=3, disp=0xFFFFFFFFFFFFFFF8.
- Bytes 66 81 C3 34 12 → len=5, opsz66=1, imm=0x1234. Bytes 66 66 66 66 66 90 → illegal, len=1.
- Backpressure and flush:
  - out_valid=1, out_ready=0, in_valid=1 → in_taken=0 and slot held for 5 cycles.
  - out_ready=1 → next instruction accepted the same cycle.
  - flush → out_valid=0.
- Bytes D6 → illegal=1, len=1. With DECODER_STATS_EN: after decoding 48 31 C0 then D6, stat_insns=2 and stat_illegal=1; reset mid-stream clears both and out_valid.
